motoro3_step_sequencer: RTL
===========================

# motoro3_step_sequencer

Commutation and PWM scheduler for the 3-phase motor drive. It advances the six-step commutation pattern at the rate set by `m3r_stepCNT_speedSET` and splits each step into up to four sub-steps. It drives the sub-step index and slope length (`lcStep`, `m3LpwmSplitStep`, `slLen`) into the PWM-length calculator and takes back the calculator's `pwmLENpos`. It then generates the six half-bridge gate signals with dead time inserted at every commutation.

## Interface
- `DEAD_CLKS`, 16: clocks with all gates off after each step change (1..255).
- `PWM_W`, 12: PWM counter width; the PWM period is 2^PWM_W clocks.
- `clk`  in  1  system clock.
- `nRst`  in  1  asynchronous active-low reset.
- `m3r_enable`  in  1  run request; low forces IDLE.
- `m3r_stepCNT_speedSET`  in  25  clocks per commutation step.
- `m3r_stepSplitMax`  in  2  highest sub-step index used (0..3).
- `pwmLENpos`  in  16  on-time from the calculator (clocks per PWM period).
- `lcStep`  out  4  current commutation step, 0..5.
- `m3LpwmSplitStep`  out  2  current sub-step index.
- `slLen`  out  16  slope length for the current sub-step.
- `m3_hi`  out  3  high-side gates, phases {C,B,A}.
- `m3_lo`  out  3  low-side gates, phases {C,B,A}.
- `stepTick`  out  1  one-cycle pulse on each step advance.
- `m3_running`  out  1  high in the DEAD or RUN state.

## Operation
- States are IDLE, DEAD and RUN, encoded as a 2-bit register.
- IDLE → DEAD when `m3r_enable`=1. On this transition:
  - `lcStep`=0, `stepCnt`=0, `deadCnt`=0, `pwmCnt`=0.
  - `speedL` and `splitL` are latched.
- DEAD → RUN when `deadCnt` = DEAD_CLKS-1.
- RUN → DEAD at a step boundary.
- Any state → IDLE when `m3r_enable`=0; the transition takes priority over everything else.
- Latched speed: `speedL` = max(`m3r_stepCNT_speedSET`, 8). `speedL` and `splitL` are re-latched only at step boundaries; changes mid-step have no effect until the next boundary.
- `stepCnt` counts 0..`speedL`-1 in both DEAD and RUN; the dead time is part of the step.
  - Step boundary: `stepCnt` = `speedL`-1.
  - At the boundary: `stepCnt`←0, `lcStep`←(`lcStep`+1) mod 6, `stepTick`=1 for one cycle, enter DEAD.
- Sub-step index: quarter length `q` = `speedL`>>2; quarter index `qi` = number of completed quarters, saturated at 3. `m3LpwmSplitStep` = min(`qi`, `splitL`).
- `slLen` is looked up from table[3-`splitL`+`m3LpwmSplitStep`], where table = {16384, 32768, 49152, 65535}.
  - The last sub-step always gets 65535.
  - With `splitL`=0, `slLen` is 65535 for the whole step.
- PWM counter:
  - `pwmCnt` (PWM_W bits) increments every clock in DEAD and RUN and wraps from 2^PWM_W-1 to 0.
  - When `pwmCnt`=0, `onLen` ← min(`pwmLENpos`, 2^PWM_W-1). This shadow register prevents glitches inside a period.
- Commutation pattern, listed as high phase / low phase for steps 0..5: A/B, A/C, B/C, B/A, C/A, C/B.
- Gates in RUN:
  - The selected high-side gate is 1 while `pwmCnt` < `onLen`.
  - The selected low-side gate is 1 for the whole step.
  - All other gates are 0.
- Gates in DEAD or IDLE: `m3_hi`=0 and `m3_lo`=0.
- The same-phase `hi` and `lo` gates are never 1 together; this is a required invariant.

## Timing
- All outputs are registered.
- Reset values: `lcStep`=0, `m3LpwmSplitStep`=0, `slLen`=0, `m3_hi`=0, `m3_lo`=0, `stepTick`=0, `m3_running`=0, state IDLE, `onLen`=0.
- `nRst` low mid-operation clears everything asynchronously; gates are off immediately.
- Enable latency:
  - `m3r_enable` sampled high at edge N: `m3_running`=1 from N+1.
  - First gate activity occurs at N+1+DEAD_CLKS.
- Disable latency: `m3r_enable` sampled low at edge N: gates and `m3_running` are 0 from N+1.
- `slLen` and `m3LpwmSplitStep` update one clock after `stepCnt` crosses a quarter boundary. The calculator is combinational, so `pwmLENpos` is valid in the same cycle. It takes effect at the next `pwmCnt` wrap.
- `stepTick` coincides with the first DEAD cycle of the new step.
- In IDLE, `slLen`=0.

## Test plan
- Reset and enable, `speedSET`=4096, `split`=0, `pwmLENpos`=0, DEAD_CLKS=16:
  - `m3_running` rises 1 clock after enable.
  - Gates are 0 throughout.
  - `stepTick` fires every 4096 clocks.
  - `lcStep` cycles 0..5→0.
- Enable with `speedSET`=65536, `split`=3, `pwmLENpos`=2048:
  - `slLen` steps 16384→32768→49152→65535 at 16384-clock intervals.
  - A-hi is high for 2048 of every 4096 clocks; B-lo stays high for the whole step.
- `split`=1, `speedSET`=8192:
  - `m3LpwmSplitStep` goes 0,1,1,1 by quarter.
  - `slLen` goes 49152,65535,65535,65535.
  - A `speedSET` write mid-step has no effect until the next `stepTick`.
- `pwmLENpos` changed 1000→3000 at `pwmCnt`=500: on-time stays 1000 until the wrap, then becomes 3000. `pwmLENpos`=0xFFFF gives on-time 4095.
- `speedSET`=3: the step length is clamped to 8 clocks. An assertion checks that no phase ever has `hi`&`lo` high.
- Disable or `nRst` pulse mid-RUN: gates are 0 the next clock (disable) or immediately (reset). Re-enable restarts at `lcStep`=0 with full dead time.

Source files
------------

// File: rtl/motoro3_step_sequencer.sv
// Six-step commutation and PWM gate scheduler for the 3-phase drive.
// Each step starts with a dead-time window; gates are derived from next-state values so every output is registered.
module motoro3_step_sequencer #(
    parameter int DEAD_CLKS = 16,
    parameter int PWM_W     = 12
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        m3r_enable,
    input  logic [24:0] m3r_stepCNT_speedSET,
    input  logic [1:0]  m3r_stepSplitMax,
    input  logic [15:0] pwmLENpos,
    output logic [3:0]  lcStep,
    output logic [1:0]  m3LpwmSplitStep,
    output logic [15:0] slLen,
    output logic [2:0]  m3_hi,
    output logic [2:0]  m3_lo,
    output logic        stepTick,
    output logic        m3_running
);

    // state | meaning
    // IDLE  | disabled, all gates off, slLen forced to 0
    // DEAD  | start of a step, all gates off for DEAD_CLKS clocks
    // RUN   | selected high side PWM-modulated, selected low side on
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [7:0]       DEAD_LAST = 8'(DEAD_CLKS - 1);
    localparam logic [15:0]      PWM_MAX16 = 16'((1 << PWM_W) - 1);
    localparam logic [PWM_W-1:0] PWM_ONE   = PWM_W'(1);

    state_t           state, state_nxt;
    logic [24:0]      step_cnt, step_nxt;
    logic [7:0]       dead_cnt, dead_nxt;
    logic [PWM_W-1:0] pwm_cnt, pwm_nxt;
    logic [PWM_W-1:0] on_len, on_nxt;
    logic [24:0]      speed_l, speed_nxt;
    logic [1:0]       split_l, split_nxt;
    logic [3:0]       lc_nxt;
    logic             tick_nxt;

    logic [24:0]      speed_clamp;
    logic [PWM_W-1:0] len_clamp;

    logic [1:0]       split_sel;
    logic [25:0]      q1, q2, q3, step_ext;
    logic [1:0]       qi, sub_d, tbl_idx;
    logic [15:0]      sl_d;
    logic [2:0]       hi_d, lo_d;
    logic             running_d;

    assign speed_clamp = (m3r_stepCNT_speedSET < 25'd8) ? 25'd8 : m3r_stepCNT_speedSET;
    assign len_clamp   = (pwmLENpos > PWM_MAX16) ? PWM_MAX16[PWM_W-1:0] : pwmLENpos[PWM_W-1:0];

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state           <= ST_IDLE;
            step_cnt        <= '0;
            dead_cnt        <= '0;
            pwm_cnt         <= '0;
            on_len          <= '0;
            speed_l         <= 25'd8;
            split_l         <= '0;
            lcStep          <= '0;
            m3LpwmSplitStep <= '0;
            slLen           <= '0;
            m3_hi           <= '0;
            m3_lo           <= '0;
            stepTick        <= 1'b0;
            m3_running      <= 1'b0;
        end else begin
            state           <= state_nxt;
            step_cnt        <= step_nxt;
            dead_cnt        <= dead_nxt;
            pwm_cnt         <= pwm_nxt;
            on_len          <= on_nxt;
            speed_l         <= speed_nxt;
            split_l         <= split_nxt;
            lcStep          <= lc_nxt;
            m3LpwmSplitStep <= sub_d;
            slLen           <= sl_d;
            m3_hi           <= hi_d;
            m3_lo           <= lo_d;
            stepTick        <= tick_nxt;
            m3_running      <= running_d;
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step_cnt;
        dead_nxt  = dead_cnt;
        pwm_nxt   = pwm_cnt;
        on_nxt    = on_len;
        speed_nxt = speed_l;
        split_nxt = split_l;
        lc_nxt    = lcStep;
        tick_nxt  = 1'b0;
        if (!m3r_enable) begin
            state_nxt = ST_IDLE;
            step_nxt  = '0;
            dead_nxt  = '0;
            pwm_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_DEAD;
                    lc_nxt    = '0;
                    step_nxt  = '0;
                    dead_nxt  = '0;
                    pwm_nxt   = '0;
                    speed_nxt = speed_clamp;
                    split_nxt = m3r_stepSplitMax;
                end
                ST_DEAD, ST_RUN: begin
                    pwm_nxt = pwm_cnt + PWM_ONE;
                    if (pwm_cnt == '0)
                        on_nxt = len_clamp;
                    // Dead time counts toward the step, so the boundary can cut DEAD short.
                    if (step_cnt == speed_l - 25'd1) begin
                        state_nxt = ST_DEAD;
                        step_nxt  = '0;
                        dead_nxt  = '0;
                        tick_nxt  = 1'b1;
                        lc_nxt    = (lcStep >= 4'd5) ? 4'd0 : lcStep + 4'd1;
                        speed_nxt = speed_clamp;
                        split_nxt = m3r_stepSplitMax;
                    end else begin
                        step_nxt = step_cnt + 25'd1;
                        if (state == ST_DEAD) begin
                            if (dead_cnt == DEAD_LAST)
                                state_nxt = ST_RUN;
                            else
                                dead_nxt = dead_cnt + 8'd1;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        running_d = (state_nxt != ST_IDLE);

        // Leaving IDLE, split_l still holds the old value and step_cnt is 0.
        split_sel = (state == ST_IDLE) ? m3r_stepSplitMax : split_l;
        q1        = {3'b000, speed_l[24:2]};
        q2        = q1 << 1;
        q3        = q1 + q2;
        step_ext  = {1'b0, step_cnt};
        if (step_ext >= q3)
            qi = 2'd3;
        else if (step_ext >= q2)
            qi = 2'd2;
        else if (step_ext >= q1)
            qi = 2'd1;
        else
            qi = 2'd0;
        sub_d   = (qi > split_sel) ? split_sel : qi;
        tbl_idx = 2'd3 - split_sel + sub_d;
        case (tbl_idx)
            2'd0:    sl_d = 16'd16384;
            2'd1:    sl_d = 16'd32768;
            2'd2:    sl_d = 16'd49152;
            default: sl_d = 16'd65535;
        endcase
        if (state_nxt == ST_IDLE) begin
            sub_d = '0;
            sl_d  = '0;
        end

        hi_d = '0;
        lo_d = '0;
        if (state_nxt == ST_RUN) begin
            case (lc_nxt)
                4'd0:    begin hi_d[0] = (pwm_nxt < on_nxt); lo_d[1] = 1'b1; end
                4'd1:    begin hi_d[0] = (pwm_nxt < on_nxt); lo_d[2] = 1'b1; end
                4'd2:    begin hi_d[1] = (pwm_nxt < on_nxt); lo_d[2] = 1'b1; end
                4'd3:    begin hi_d[1] = (pwm_nxt < on_nxt); lo_d[0] = 1'b1; end
                4'd4:    begin hi_d[2] = (pwm_nxt < on_nxt); lo_d[0] = 1'b1; end
                4'd5:    begin hi_d[2] = (pwm_nxt < on_nxt); lo_d[1] = 1'b1; end
                default: begin hi_d = '0; lo_d = '0; end
            endcase
        end
    end

endmodule
